ram8_port: RTL and testbench

//   8-word x WIDTH register-file memory (Hack RAM8 stage) that consumes the one-hot load

---
 rtl/ram8_pkg.sv | 15 +
 rtl/ram8_port_dmux8way.sv | 16 +
 rtl/ram8_port.sv | 110 +++++++++++
 tb/tb_ram8_port.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram8_pkg.sv
// Shared types and sizes for the 8-word register-file memory.
// Depth is fixed by the 8-way load demultiplexer, so the address is always 3 bits.
package ram8_pkg;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_t;

  typedef logic [AW-1:0] addr_t;

endpackage

// File: rtl/ram8_port_dmux8way.sv
// 8-way demultiplexer: routes a single enable onto one of eight outputs.
// Used by ram8_port to turn an accepted write into a one-hot word load enable.
module dmux8way
  import ram8_pkg::*;
(
  input  logic             in,
  input  addr_t            sel,
  output logic [DEPTH-1:0] out
);

  always_comb begin
    out      = '0;
    out[sel] = in;
  end

endmodule

// File: rtl/ram8_port.sv
// 8-word x WIDTH register-file memory with a valid/ready request channel,
// a single-entry buffered response channel and an in-order dump engine.
//
// state | meaning
// IDLE  | requests accepted whenever the response slot is free
// DUMP  | streaming word[ptr] onto the response channel, requests blocked
module ram8_port
  import ram8_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  addr_t            req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output addr_t            rsp_addr,
  input  logic             dump_start,
  output logic             busy
);

  state_t           state;
  addr_t            ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] load;

  logic slot_free;
  logic accept;
  logic wr_accept;
  logic rd_accept;
  logic dump_load;

  assign slot_free = !rsp_valid || rsp_ready;
  // Gated by rst_n so nothing can be handshaken while the memory is being cleared.
  assign req_ready = rst_n && (state == IDLE) && !dump_start && slot_free;
  assign accept    = req_valid && req_ready;
  assign wr_accept = accept && req_we;
  assign rd_accept = accept && !req_we;
  assign dump_load = (state == DUMP) && slot_free;
  assign busy      = (state == DUMP);

  dmux8way u_load_dmux (
    .in  (wr_accept),
    .sel (req_addr),
    .out (load)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[i] <= '0;
      end else if (load[i]) begin
        mem[i] <= req_wdata;
      end
    end
  end

  // A read and a dump load can never coincide: reads need IDLE, dump loads need DUMP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
    end else if (rd_accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= mem[req_addr];
      rsp_addr  <= req_addr;
    end else if (dump_load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= mem[ptr];
      rsp_addr  <= ptr;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            state <= DUMP;
            ptr   <= '0;
          end
        end
        DUMP: begin
          if (slot_free) begin
            ptr <= ptr + addr_t'(1);
            if (ptr == addr_t'(DEPTH - 1)) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_port.sv
// Randomised scoreboard bench for ram8_port: a plain array models the memory,
// expected responses are queued at issue time and popped by an independent monitor.
module tb_ram8_port;
  import ram8_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [2:0]   req_addr = '0;
  logic [W-1:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [2:0]   rsp_addr;
  logic         dump_start = 1'b0;
  logic         busy;

  always #5 clk = ~clk;

  ram8_port #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .dump_start (dump_start),
    .busy       (busy)
  );

  typedef struct packed {
    logic [2:0]   a;
    logic [W-1:0] d;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] model [8];
  int           checks = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=timeout expected=event", name);
  endtask

  // Monitor: pops one expected word per taken response and checks hold stability.
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_d = '0;
  logic [2:0]   prev_a = '0;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_data", 32'(rsp_data), 32'(prev_d));
        check("hold_addr", 32'(rsp_addr), 32'(prev_a));
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected got addr=%0d data=%0h expected=none", rsp_addr, rsp_data);
        end else begin
          mon_e = sbq.pop_front();
          check("sb_addr", 32'(rsp_addr), 32'(mon_e.a));
          check("sb_data", 32'(rsp_data), 32'(mon_e.d));
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_d    = rsp_data;
      prev_a    = rsp_addr;
    end
  end

  task automatic push_exp(input logic [2:0] a);
    exp_t e;
    e.a = a;
    e.d = model[a];
    sbq.push_back(e);
  endtask

  task automatic do_req(input bit we, input logic [2:0] a, input logic [W-1:0] d, input bit rnd);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) begin
      timeout("req_accept");
      req_valid = 1'b0;
    end else begin
      if (we) model[a] = d;
      else push_exp(a);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic start_dump();
    dump_start = 1'b1;
    for (int k = 0; k < 8; k++) push_exp(3'(k));
    @(posedge clk);
    #1;
    dump_start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!busy && !(rnd && rsp_valid && !rsp_ready)) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) timeout("wait_idle");
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int n = 0; n < 50 && sbq.size() != 0; n++) @(posedge clk);
    @(posedge clk);
    #1;
    check("sb_drain", 32'(sbq.size()), 32'd0);
  endtask

  int cnt, first, last;
  bit found;

  initial begin
    for (int k = 0; k < 8; k++) model[k] = '0;

    // Reset values
    #3;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_addr", 32'(rsp_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Write / read
    rsp_ready = 1'b1;
    do_req(1'b1, 3'd3, 16'hBEEF, 1'b0);
    do_req(1'b0, 3'd3, '0, 1'b0);
    check("rd3_valid", 32'(rsp_valid), 32'd1);
    check("rd3_data", 32'(rsp_data), 32'hBEEF);
    check("rd3_addr", 32'(rsp_addr), 32'd3);
    do_req(1'b0, 3'd4, '0, 1'b0);
    check("rd4_data", 32'(rsp_data), 32'h0000);
    @(posedge clk);
    #1;

    // Backpressure
    rsp_ready = 1'b0;
    do_req(1'b0, 3'd3, '0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'hBEEF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_taken", 32'(rsp_valid), 32'd0);

    // Full dump, with a request colliding with dump_start
    for (int k = 0; k < 8; k++) do_req(1'b1, 3'(k), 16'h1110 + 16'(k), 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 3'd0;
    dump_start = 1'b1;
    @(negedge clk);
    check("collide_req_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 8; k++) push_exp(3'(k));
    @(posedge clk);
    #1;
    dump_start = 1'b0;
    req_valid  = 1'b0;
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) check("dump_busy", 32'(busy), 32'd1);
      if (rsp_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
        if (rsp_addr == 3'd7) check("dump_busy_drop", 32'(busy), 32'd0);
      end
    end
    check("dump_count", 32'(cnt), 32'd8);
    check("dump_consecutive", 32'(last - first), 32'd7);
    @(posedge clk);
    #1;

    // Dump with a stall while the pointer sits at 2
    start_dump();
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid && rsp_addr == 3'd1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!found) timeout("stall_find_ptr2");
    rsp_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("stall_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    wait_idle(1'b0);
    drain();

    // Randomised traffic
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        start_dump();
        wait_idle(1'b1);
      end else begin
        do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 1'b1);
      end
    end
    drain();

    // Reset in the middle of a dump
    for (int k = 0; k < 8; k++) do_req(1'b1, 3'(k), 16'hA5A0 + 16'(k), 1'b0);
    start_dump();
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid && rsp_addr == 3'd4) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!found) timeout("midrst_find_ptr5");
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(rsp_data), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    sbq.delete();
    for (int k = 0; k < 8; k++) model[k] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_idle_busy", 32'(busy), 32'd0);
    do_req(1'b0, 3'd5, '0, 1'b0);
    check("midrst_rd5_valid", 32'(rsp_valid), 32'd1);
    check("midrst_rd5_data", 32'(rsp_data), 32'd0);
    for (int k = 0; k < 8; k++) do_req(1'b0, 3'(k), '0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
